// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared state enum, default widths and saturation bounds for the PE tile
package pe_pkg;

    localparam int MAC_ROW_DEF = 4;
    localparam int MAC_COL_DEF = 8;
    localparam int BW_ACT_DEF  = 8;
    localparam int BW_WET_DEF  = 8;
    localparam int BW_ACCU_DEF = 32;
    localparam int BW_OUT_DEF  = 8;
    localparam int SHIFT_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } pe_state_e;

    // Largest (hi=1) or smallest (hi=0) value representable in a signed bw_out-bit output lane.
    function automatic int sat_bound(input int bw_out, input bit hi);
        int mag;
        mag = 1 << (bw_out - 1);
        return hi ? (mag - 1) : -mag;
    endfunction

endpackage

// File: rtl/pe_requant.sv
// rtl/pe_requant.sv - one output lane: round-half-up arithmetic shift then saturate
module pe_requant
    import pe_pkg::*;
#(
    parameter int BW_ACCU = BW_ACCU_DEF,
    parameter int BW_OUT  = BW_OUT_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic [BW_ACCU-1:0] acc_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic [BW_OUT-1:0]  data_o
);

    localparam logic signed [BW_ACCU:0] SAT_HI = (BW_ACCU + 1)'(sat_bound(BW_OUT, 1'b1));
    localparam logic signed [BW_ACCU:0] SAT_LO = (BW_ACCU + 1)'(sat_bound(BW_OUT, 1'b0));

    logic [31:0]             shift_eff;
    logic signed [BW_ACCU:0] acc_ext;
    logic signed [BW_ACCU:0] half;
    logic signed [BW_ACCU:0] shifted;

    // One extra bit of headroom keeps the rounding add from overflowing before the shift.
    always_comb begin
        shift_eff = 32'(shift_i);
        if (shift_eff > 32'(BW_ACCU - 1)) begin
            shift_eff = 32'(BW_ACCU - 1);
        end
        acc_ext = {acc_i[BW_ACCU-1], acc_i};
        half    = '0;
        if (shift_eff != 32'd0) begin
            half = (BW_ACCU + 1)'(1) << (shift_eff - 32'd1);
        end
        shifted = (acc_ext + half) >>> shift_eff;
        if (shifted > SAT_HI) begin
            data_o = SAT_HI[BW_OUT-1:0];
        end else if (shifted < SAT_LO) begin
            data_o = SAT_LO[BW_OUT-1:0];
        end else begin
            data_o = shifted[BW_OUT-1:0];
        end
    end

endmodule

// File: rtl/pe_tile_mac.sv
// rtl/pe_tile_mac.sv - MAC_ROW x MAC_COL outer-product accumulate tile with requantised row drain
module pe_tile_mac
    import pe_pkg::*;
#(
    parameter int MAC_ROW  = MAC_ROW_DEF,
    parameter int MAC_COL  = MAC_COL_DEF,
    parameter int BW_ACT   = BW_ACT_DEF,
    parameter int BW_WET   = BW_WET_DEF,
    parameter int BW_ACCU  = BW_ACCU_DEF,
    parameter int BW_OUT   = BW_OUT_DEF,
    parameter int SHIFT_W  = SHIFT_W_DEF,
    localparam int ROW_W   = (MAC_ROW > 1) ? $clog2(MAC_ROW) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [MAC_COL*BW_ACT-1:0] in_act,
    input  logic [MAC_ROW*BW_WET-1:0] in_wet,
    input  logic [SHIFT_W-1:0]        shift_num,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAC_COL*BW_OUT-1:0] out_data,
    output logic [ROW_W-1:0]          out_row,
    output logic                      out_last,
    output logic                      busy
);

    localparam int PW = BW_ACT + BW_WET;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAC_ROW - 1);

    pe_state_e            state_q, state_d;
    logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [BW_ACCU-1:0]   acc_q [MAC_ROW][MAC_COL];
    logic [BW_ACCU-1:0]   acc_d [MAC_ROW][MAC_COL];
    logic signed [PW-1:0] prod  [MAC_ROW][MAC_COL];
    logic [MAC_COL*BW_OUT-1:0] rq_data;
    logic in_fire;
    logic out_fire;
    logic last_row;

    assign in_ready  = (state_q != ST_DRAIN);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_q == ST_DRAIN);
    assign out_fire  = out_valid && out_ready;
    assign last_row  = (row_cnt_q == LAST_ROW);
    assign out_row   = row_cnt_q;
    assign out_last  = out_valid && last_row;
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_valid ? rq_data : '0;

    // Full-precision signed products, one per tile cell.
    for (genvar r = 0; r < MAC_ROW; r++) begin : g_prod_row
        for (genvar c = 0; c < MAC_COL; c++) begin : g_prod_col
            assign prod[r][c] = $signed(in_wet[r*BW_WET +: BW_WET]) * $signed(in_act[c*BW_ACT +: BW_ACT]);
        end
    end

    // Requantise the row currently being drained; output is purely a function of registered state.
    for (genvar c = 0; c < MAC_COL; c++) begin : g_rq
        pe_requant #(
            .BW_ACCU (BW_ACCU),
            .BW_OUT  (BW_OUT),
            .SHIFT_W (SHIFT_W)
        ) u_rq (
            .acc_i   (acc_q[row_cnt_q][c]),
            .shift_i (shift_q),
            .data_o  (rq_data[c*BW_OUT +: BW_OUT])
        );
    end

    // Next state: a last beat always goes straight to drain, even from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    state_d = in_last ? ST_DRAIN : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_fire && in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_fire && last_row) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Row counter walks the drain; shift is captured with the closing beat.
    always_comb begin
        row_cnt_d = row_cnt_q;
        shift_d   = shift_q;
        if (out_fire) begin
            row_cnt_d = last_row ? '0 : row_cnt_q + ROW_W'(1);
        end
        if (in_fire && in_last) begin
            shift_d = shift_num;
        end
    end

    // Accumulate on every accepted beat; in_first replaces the old sum instead of adding to it.
    always_comb begin
        for (int r = 0; r < MAC_ROW; r++) begin
            for (int c = 0; c < MAC_COL; c++) begin
                acc_d[r][c] = acc_q[r][c];
                if (in_fire) begin
                    acc_d[r][c] = (in_first ? '0 : acc_q[r][c]) + BW_ACCU'(prod[r][c]);
                end
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            row_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // Accumulator array; kept across jobs until the next in_first beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < MAC_ROW; r++) begin
                for (int c = 0; c < MAC_COL; c++) begin
                    acc_q[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < MAC_ROW; r++) begin
                for (int c = 0; c < MAC_COL; c++) begin
                    acc_q[r][c] <= acc_d[r][c];
                end
            end
        end
    end

endmodule
